// File: rtl/adc_touch_responder_if.sv
// rtl/adc_touch_responder_if.sv - serial ADC link between touch controller and ADC responder
interface adc_touch_responder_if;
  logic adc_cs_n;
  logic adc_dclk;
  logic adc_din;
  logic adc_dout;
  logic adc_busy;

  modport master (
    output adc_cs_n, adc_dclk, adc_din,
    input  adc_dout, adc_busy
  );

  modport slave (
    input  adc_cs_n, adc_dclk, adc_din,
    output adc_dout, adc_busy
  );
endinterface

// File: rtl/adc_touch_responder.sv
// rtl/adc_touch_responder.sv - serial-ADC stand-in returning 12-bit X/Y samples
// Optional conversion counter enabled by defining ADC_RESP_CNT_EN.
module adc_touch_responder #(
  parameter int         CMD_BITS    = 8,
  parameter int         DATA_BITS   = 12,
  parameter logic [2:0] CH_X        = 3'b001,
  parameter logic [2:0] CH_Y        = 3'b101,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adc_touch_responder_if.slave bus,
  input  logic [DATA_BITS-1:0] x_value,
  input  logic [DATA_BITS-1:0] y_value,
  output logic                 cmd_err,
  output logic [7:0]           conv_count
);

  localparam logic [3:0] CMD_LAST  = 4'(CMD_BITS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    CMD        = 3'd2,
    BUSY       = 3'd3,
    DATA       = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] dclk_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   dclk_q;
  logic                   cs_s;
  logic                   dclk_s;
  logic                   din_s;
  logic                   rise;
  logic                   fall;

  state_t                 state, state_n;
  logic [CMD_BITS-3:0]    cmd_sr, cmd_n;
  logic [3:0]             bit_cnt, cnt_n;
  logic [DATA_BITS-1:0]   snap, snap_n;
  logic                   dout_q, dout_n;
  logic                   busy_q, busy_n;
  logic                   err_n;
  logic                   done;
  logic [2:0]             chan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '1;
      dclk_sync <= '1;
      din_sync  <= '0;
      dclk_q    <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.adc_cs_n};
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], bus.adc_dclk};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], bus.adc_din};
      dclk_q    <= dclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign dclk_s = dclk_sync[SYNC_STAGES-1];
  assign din_s  = din_sync[SYNC_STAGES-1];
  assign rise   = dclk_s & ~dclk_q;
  assign fall   = ~dclk_s & dclk_q;

  // The start bit is not stored, so after 7 rises the register holds bits 6..1.
  assign chan = cmd_sr[CMD_BITS-3 -: 3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cmd_sr  <= '0;
      bit_cnt <= '0;
      snap    <= '0;
      dout_q  <= 1'b0;
      busy_q  <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state   <= state_n;
      cmd_sr  <= cmd_n;
      bit_cnt <= cnt_n;
      snap    <= snap_n;
      dout_q  <= dout_n;
      busy_q  <= busy_n;
      cmd_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cmd_n   = cmd_sr;
    cnt_n   = bit_cnt;
    snap_n  = snap;
    dout_n  = dout_q;
    busy_n  = busy_q;
    err_n   = 1'b0;
    done    = 1'b0;
    if (cs_s) begin
      state_n = IDLE;
      cmd_n   = '0;
      cnt_n   = '0;
      dout_n  = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = WAIT_START;
        WAIT_START: begin
          if (rise && din_s) begin
            cmd_n   = '0;
            cnt_n   = 4'd1;
            state_n = CMD;
          end
        end
        CMD: begin
          if (rise) begin
            cmd_n = {cmd_sr[CMD_BITS-4:0], din_s};
            cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == CMD_LAST) begin
              cnt_n   = '0;
              busy_n  = 1'b1;
              state_n = BUSY;
              if (chan == CH_X) begin
                snap_n = x_value;
              end else if (chan == CH_Y) begin
                snap_n = y_value;
              end else begin
                snap_n = '0;
                err_n  = 1'b1;
              end
            end
          end
        end
        BUSY: begin
          if (fall) begin
            busy_n  = 1'b0;
            dout_n  = snap[DATA_BITS-1];
            snap_n  = snap << 1;
            cnt_n   = 4'd1;
            state_n = DATA;
          end
        end
        DATA: begin
          if (fall) begin
            if (bit_cnt == DATA_LAST) begin
              dout_n  = 1'b0;
              cnt_n   = '0;
              done    = 1'b1;
              state_n = WAIT_START;
            end else begin
              dout_n = snap[DATA_BITS-1];
              snap_n = snap << 1;
              cnt_n  = bit_cnt + 4'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.adc_dout = dout_q;
  assign bus.adc_busy = busy_q;

`ifdef ADC_RESP_CNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'h00;
    end else if (done) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign conv_count = cnt_q;
`else
  logic unused_done;

  assign unused_done = done;
  assign conv_count  = 8'h00;
`endif

endmodule
